// File: rtl/api_resp.sv
// Chip-side responder for the api serial link: deserialises 32-bit work words
// from sck/mosi under load_n, and serialises result blocks back on miso.
module api_resp #(
  parameter int unsigned WORK_LEN  = 23,
  parameter int unsigned RES_LEN   = 11,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_n_i,
  input  logic        sck_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        rx_vld_o,
  output logic [31:0] rx_dat_o,
  output logic [4:0]  rx_idx_o,
  output logic        frame_done_o,
  output logic        frame_abort_o,
  input  logic [31:0] res_dout_i,
  input  logic [9:0]  res_count_i,
  output logic        res_rd_en_o,
  output logic [15:0] frame_cnt_o,
  output logic        state_o
);

  localparam logic [4:0] LAST_IDX  = 5'(WORK_LEN - 1);
  localparam logic [4:0] RES_IDX   = 5'(RES_LEN);
  localparam logic [9:0] RES_NEED  = 10'(RES_LEN);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state_q, state_d;

  // Sync chains: index 1 is the synchronised value, index 2 the delayed copy for edges.
  logic [2:0] load_n_s_q, sck_s_q;
  logic [1:0] mosi_s_q;

  logic load_fall, load_rise, sck_rise, sck_fall, mosi_b;
  assign load_fall = ~load_n_s_q[1] &  load_n_s_q[2];
  assign load_rise =  load_n_s_q[1] & ~load_n_s_q[2];
  assign sck_rise  =  sck_s_q[1]    & ~sck_s_q[2];
  assign sck_fall  = ~sck_s_q[1]    &  sck_s_q[2];
  assign mosi_b    =  mosi_s_q[1];

  logic [31:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, rx_dat_q, rx_dat_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d, word_idx_q, word_idx_d, rx_idx_q, rx_idx_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        blk_act_q, blk_act_d, word_done_q, word_done_d;
  logic        rx_vld_q, rx_vld_d, done_q, done_d, abort_q, abort_d, pop_q, pop_d;
  logic        blk_ok, tx_from_fifo;

  assign blk_ok       = res_count_i >= RES_NEED;
  assign tx_from_fifo = blk_act_q && (word_idx_q < RES_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_fall) state_d = SHIFT;
      SHIFT:   if (load_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rx_vld is a one-clk strobe with no backpressure; res_rd_en pops exactly one
  // word from a first-word fall-through FIFO whose head was just consumed.
  always_comb begin
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_dat_d    = rx_dat_q;
    rx_idx_d    = rx_idx_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    frame_cnt_d = frame_cnt_q;
    blk_act_d   = blk_act_q;
    word_done_d = 1'b0;
    rx_vld_d    = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    pop_d       = 1'b0;
    if (state_q == IDLE) begin
      if (load_fall) begin
        blk_act_d  = blk_ok;
        tx_sr_d    = blk_ok ? res_dout_i : IDLE_WORD;
        pop_d      = blk_ok;
        bit_cnt_d  = '0;
        word_idx_d = '0;
      end
    end else if (load_rise) begin
      // Deselect outranks any sck edge seen in the same clk.
      abort_d    = (bit_cnt_q != '0) || (word_idx_q != '0);
      bit_cnt_d  = '0;
      word_idx_d = '0;
    end else begin
      if (word_done_q) begin
        rx_vld_d = 1'b1;
        rx_dat_d = rx_sr_q;
        rx_idx_d = word_idx_q;
        if (word_idx_q == LAST_IDX) begin
          word_idx_d  = '0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          blk_act_d   = blk_ok;
        end else begin
          word_idx_d = word_idx_q + 5'd1;
        end
      end
      if (sck_rise) begin
        rx_sr_d     = {rx_sr_q[30:0], mosi_b};
        bit_cnt_d   = bit_cnt_q + 5'd1;
        word_done_d = (bit_cnt_q == 5'd31);
      end else if (sck_fall) begin
        if (bit_cnt_q == '0) begin
          tx_sr_d = tx_from_fifo ? res_dout_i : IDLE_WORD;
          pop_d   = tx_from_fifo;
        end else begin
          tx_sr_d = {tx_sr_q[30:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      load_n_s_q  <= 3'b111;
      sck_s_q     <= 3'b000;
      mosi_s_q    <= 2'b00;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_dat_q    <= '0;
      rx_idx_q    <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      frame_cnt_q <= '0;
      blk_act_q   <= 1'b0;
      word_done_q <= 1'b0;
      rx_vld_q    <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      pop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_n_s_q  <= {load_n_s_q[1:0], load_n_i};
      sck_s_q     <= {sck_s_q[1:0], sck_i};
      mosi_s_q    <= {mosi_s_q[0], mosi_i};
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_dat_q    <= rx_dat_d;
      rx_idx_q    <= rx_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      frame_cnt_q <= frame_cnt_d;
      blk_act_q   <= blk_act_d;
      word_done_q <= word_done_d;
      rx_vld_q    <= rx_vld_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      pop_q       <= pop_d;
    end
  end

  assign miso_o        = (state_q == SHIFT) ? tx_sr_q[31] : 1'b1;
  assign rx_vld_o      = rx_vld_q;
  assign rx_dat_o      = rx_dat_q;
  assign rx_idx_o      = rx_idx_q;
  assign frame_done_o  = done_q;
  assign frame_abort_o = abort_q;
  assign res_rd_en_o   = pop_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_api_resp.sv
// Directed bench for api_resp: acts as the link master (sck/mosi/load_n) and as
// the result FIFO, with a scoreboard of expected received words.
module tb_api_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_n = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso, rx_vld, frame_done, frame_abort, res_rd_en, dbg_state;
  logic [31:0] rx_dat;
  logic [4:0]  rx_idx;
  logic [15:0] frame_cnt;
  logic [31:0] res_dout = '0;
  logic [9:0]  res_count = '0;

  api_resp dut (
    .clk(clk), .rst(rst), .load_n_i(load_n), .sck_i(sck), .mosi_i(mosi),
    .miso_o(miso), .rx_vld_o(rx_vld), .rx_dat_o(rx_dat), .rx_idx_o(rx_idx),
    .frame_done_o(frame_done), .frame_abort_o(frame_abort),
    .res_dout_i(res_dout), .res_count_i(res_count), .res_rd_en_o(res_rd_en),
    .frame_cnt_o(frame_cnt), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  exp_idx_q[$];
  logic [31:0] fifo_q[$];
  int pop_cnt = 0, pop_mark = 0, frame_pops = 0, done_cnt = 0, abort_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fifo_word(input int k);
    return (k == 9) ? 32'hbeafbeaf : 32'hA000_0000 + 32'(k);
  endfunction

  task automatic fifo_refresh();
    res_count = 10'(fifo_q.size());
    res_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic fifo_fill(input int first_k, input int n);
    for (int k = first_k; k < first_k + n; k++) fifo_q.push_back(fifo_word(k));
    fifo_refresh();
  endtask

  // Scoreboard and FIFO model, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_vld) begin
        if (exp_q.size() == 0) check("rx_unexp", rx_vld, 1'b0);
        else begin
          check("rx_dat", rx_dat, exp_q.pop_front());
          check("rx_idx", rx_idx, exp_idx_q.pop_front());
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("done_idx", rx_idx, 5'd22);
        check("done_vld", rx_vld, 1'b1);
        frame_pops = pop_cnt - pop_mark;
        pop_mark   = pop_cnt;
      end
      if (frame_abort) abort_cnt++;
      if (res_rd_en) begin
        pop_cnt++;
        if (fifo_q.size() == 0) check("fifo_underflow", res_rd_en, 1'b0);
        else void'(fifo_q.pop_front());
        fifo_refresh();
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #5;
  endtask

  task automatic select();
    align();
    load_n = 1'b0;
    #100;
  endtask

  task automatic deselect();
    load_n = 1'b1;
    #100;
  endtask

  // Shift nbits of w MSB first, sampling miso on each rise; all edges land on 10ns multiples.
  task automatic xfer_word(input logic [31:0] w, input int nbits, output logic [31:0] m);
    logic [3:0] vld;
    m = '0;
    for (int b = 0; b < nbits; b++) begin
      mosi = w[31-b];
      #40;
      sck = 1'b1;
      m[31-b] = miso;
      if (b == 31) begin
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #1;
          vld[k] = rx_vld;
        end
        #4;
        check("rx_latency", {28'd0, vld}, 32'h8);
      end else begin
        #40;
      end
      sck = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input logic [31:0] exp_miso);
    logic [31:0] m;
    exp_q.push_back(w);
    exp_idx_q.push_back(5'(idx));
    xfer_word(w, 32, m);
    check("miso_word", m, exp_miso);
  endtask

  typedef struct {
    bit          new_sel;
    bit          end_sel;
    logic [31:0] mosi_base;
    int          fill;
    bit          late;
    bit          exp_blk;
  } frame_vec_t;

  frame_vec_t vecs[4];

  initial begin
    logic [31:0] m;
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0000,  0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h5000_0000, 11, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h1234_0000, 10, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'hC0DE_0000,  0, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", miso, 1'b1);
    check("rst_rx_vld", rx_vld, 1'b0);
    check("rst_rx_dat", rx_dat, 32'h0);
    check("rst_rx_idx", rx_idx, 5'd0);
    check("rst_done", frame_done, 1'b0);
    check("rst_abort", frame_abort, 1'b0);
    check("rst_rd_en", res_rd_en, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_state", dbg_state, 1'b0);
    align();
    rst = 1'b0;
    #50;

    // Ignored edges while deselected.
    for (int b = 0; b < 4; b++) begin sck = 1'b1; #40; sck = 1'b0; #40; end
    check("idle_rx_vld", rx_vld, 1'b0);
    check("idle_state", dbg_state, 1'b0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].new_sel) begin
        fifo_fill(0, vecs[v].fill);
        select();
      end
      for (int i = 0; i < 23; i++) begin
        if (vecs[v].late && i == 5) fifo_fill(10, 1);
        send_word(vecs[v].mosi_base + 32'(i), i,
                  (vecs[v].exp_blk && i < 11) ? fifo_word(i) : 32'h0);
      end
      #100;
      check("frame_done_cnt", done_cnt, v + 1);
      check("frame_cnt", frame_cnt, 16'(v + 1));
      check("frame_pops", frame_pops, vecs[v].exp_blk ? 11 : 0);
      if (vecs[v].end_sel) deselect();
    end
    check("total_pops", pop_cnt, 22);
    check("fifo_empty", fifo_q.size(), 0);
    check("abort_none", abort_cnt, 0);

    // Abort after 17 bits of word 5.
    select();
    for (int i = 0; i < 5; i++) send_word(32'h4400_0000 + 32'(i), i, 32'h0);
    xfer_word(32'hDEAD_BEEF, 17, m);
    #40;
    load_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pulse", frame_abort, 1'b1);
    check("abort_miso", miso, 1'b1);
    #100;
    check("abort_cnt1", abort_cnt, 1);
    select();
    send_word(32'h5555_AAAA, 0, 32'h0);
    send_word(32'h0F0F_0F0F, 1, 32'h0);
    #40;
    deselect();
    check("abort_cnt2", abort_cnt, 2);

    // Asynchronous reset at bit 12 of word 3.
    select();
    for (int i = 0; i < 3; i++) send_word(32'h7700_0000 + 32'(i), i, 32'h0);
    xfer_word(32'hFFFF_FFFF, 12, m);
    #13;
    rst = 1'b1;
    #1;
    check("arst_miso", miso, 1'b1);
    check("arst_rx_vld", rx_vld, 1'b0);
    check("arst_rx_dat", rx_dat, 32'h0);
    check("arst_rx_idx", rx_idx, 5'd0);
    check("arst_frame_cnt", frame_cnt, 16'd0);
    check("arst_rd_en", res_rd_en, 1'b0);
    check("arst_state", dbg_state, 1'b0);
    #20;
    load_n = 1'b1;
    #30;
    align();
    rst = 1'b0;
    #100;
    check("arst_no_abort", abort_cnt, 2);
    select();
    send_word(32'h1357_9BDF, 0, 32'h0);
    send_word(32'h2468_ACE0, 1, 32'h0);
    #40;
    deselect();
    check("post_rst_frame_cnt", frame_cnt, 16'd0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
